// File: rtl/fft_frame_loader_pkg.sv
// Shared constants, bank state encoding and slot/word packing helpers for the
// FFT frame loader. The FFT_LOADER_BITREV_EN macro is consumed by the top.
package fft_frame_loader_pkg;

  localparam int N_POINTS = 32;
  localparam int LOG2N    = 5;
  localparam int DATA_W   = 32;
  localparam int FRAME_W  = 2 * N_POINTS * DATA_W;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Slot k holds real in word 2k and imaginary in word 2k+1.
  function automatic logic [LOG2N:0] word_idx(input logic [LOG2N-1:0] slot,
                                              input logic is_im);
    return {slot, is_im};
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = idx[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N_POINTS-slot complex register bank with slot-addressed writes, a
// synchronous clear and a packed read-out in the butterfly input format.
module fft_frame_bank
  import fft_frame_loader_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic               we,
  input  logic [LOG2N-1:0]   addr,
  input  logic [DATA_W-1:0]  wr_re,
  input  logic [DATA_W-1:0]  wr_im,
  output logic [FRAME_W-1:0] frame
);

  logic [DATA_W-1:0] words [2*N_POINTS];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int w = 0; w < 2*N_POINTS; w++) words[w] <= '0;
    end else if (we) begin
      words[word_idx(addr, 1'b0)] <= wr_re;
      words[word_idx(addr, 1'b1)] <= wr_im;
    end
  end

  always_comb begin
    frame = '0;
    for (int w = 0; w < 2*N_POINTS; w++) frame[w*DATA_W +: DATA_W] = words[w];
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame assembler feeding the 32-point butterfly pipeline.
// Define FFT_LOADER_BITREV_EN to store samples at bit-reversed slots.
module fft_frame_loader
  import fft_frame_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_re,
  input  logic [DATA_W-1:0]  s_im,
  input  logic               s_last,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               err_short,
  output logic               err_long
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and data is held while valid && !ready.
  bank_state_t        state_q [2];
  bank_state_t        state_d [2];
  logic               wr_bank;
  logic               rd_bank;
  logic [LOG2N-1:0]   count;
  logic [LOG2N-1:0]   slot;
  logic               accept;
  logic               take;
  logic               at_last;
  logic [FRAME_W-1:0] bank_frame [2];

  assign s_ready     = reset && (state_q[wr_bank] != BANK_FULL);
  assign frame_valid = (state_q[rd_bank] == BANK_FULL);
  assign frame_out   = bank_frame[rd_bank];
  assign accept      = s_valid && s_ready;
  assign take        = frame_valid && frame_ready;
  assign at_last     = (count == LOG2N'(N_POINTS-1));

`ifdef FFT_LOADER_BITREV_EN
  assign slot = bitrev(count);
`else
  assign slot = count;
`endif

  // An early s_last leaves the bank FILLING so the next frame overwrites it.
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    if (accept) state_d[wr_bank] = at_last ? BANK_FULL : BANK_FILLING;
    if (take)   state_d[rd_bank] = BANK_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      count      <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      if (take) rd_bank <= ~rd_bank;
      if (accept) begin
        if (at_last) begin
          wr_bank <= ~wr_bank;
          count   <= '0;
          if (!s_last) err_long <= 1'b1;
        end else if (s_last) begin
          count     <= '0;
          err_short <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank u_bank (
      .clk   (clk),
      .clear (!reset),
      .we    (accept && (wr_bank == 1'(b))),
      .addr  (slot),
      .wr_re (s_re),
      .wr_im (s_im),
      .frame (bank_frame[b])
    );
  end

endmodule
